dsp_pwr_seq: RTL
================

Name: dsp_pwr_seq

Overview:
- Timed power-up/reset sequencer for the DSP. It drives the two edge inputs of the downstream power-on/reset latch stage: pwron_out first, then rst_out.
- Counts programmable delays from the board clock.
- Checks the regulator power-good between the two edges.
- Handles fault and orderly shutdown.

Parameters:
- CNT_W, 20: width of the shared delay counter. Every *_CYC value must be < 2**CNT_W.
- PWR_DLY_CYC, 50000: cycles from enable to pwron_out rise. Minimum 1.
- PG_TIMEOUT_CYC, 20000: maximum cycles to wait for synchronized pwr_good after pwron_out rises. Minimum 1.
- RST_DLY_CYC, 100000: cycles from synchronized pwr_good high to rst_out rise. Minimum 1.
- SHDN_DLY_CYC, 1000: cycles between rst_out fall and pwron_out fall on shutdown. Minimum 1.
- MAX_RETRY, 3: retry attempts. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  sequence enable, synchronous to clk. 1 = power up DSP, 0 = shut down.
- pwr_good  in  1  regulator power-good. Asynchronous; synchronized internally.
- pwron_out  out  1  DSP power-on request. Registered level; its rising edge feeds the power-on latch.
- rst_out  out  1  DSP reset release. Registered level; its rising edge feeds the reset latch.
- busy  out  1  high in any state other than IDLE, RUN and FAULT.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0.
  - pwron_out=0, rst_out=0, busy=0, fault=0.
  - pwr_good synchronizer flops cleared.
- pwr_good passes through a 2-flop synchronizer (pg_s). All decisions use pg_s, so pwr_good has 2 cycles of latency.
- All outputs are registered; no glitches. rst_out is never 1 while pwron_out is 0.
- States and transitions:
  - IDLE:
    - en=1 at edge N → WAIT_PWR with counter=1.
  - WAIT_PWR:
    - Counter increments each cycle.
    - pwron_out goes high at edge N+PWR_DLY_CYC → WAIT_PG, counter=0.
  - WAIT_PG:
    - pg_s=1 → WAIT_RST, counter=0.
    - Else counter increments.
    - Counter reaching PG_TIMEOUT_CYC without pg_s → FAULT.
  - WAIT_RST:
    - pg_s=0 at any cycle → FAULT.
    - Counter reaching RST_DLY_CYC → rst_out=1, go to RUN.
  - RUN:
    - Outputs held (pwron_out=1, rst_out=1).
    - pg_s=0 → FAULT.
  - SHUTDOWN:
    - rst_out=0 on entry edge.
    - pwron_out=0 after SHDN_DLY_CYC further cycles → IDLE.
  - FAULT:
    - pwron_out=0 and rst_out=0 on the entry edge (both in the same cycle). fault=1.
    - Stays in FAULT until en=0 → IDLE (fault clears).
- en=0 handling:
  - en=0 in WAIT_PWR → IDLE immediately; pwron_out is still 0.
  - en=0 in WAIT_PG, WAIT_RST or RUN → SHUTDOWN.
  - en=0 in SHUTDOWN → no effect.
  - en=1 during SHUTDOWN is ignored; the shutdown completes to IDLE, and a new sequence starts from IDLE.
- Simultaneous events: a FAULT condition and en=0 in the same cycle → FAULT wins.
- Counter:
  - Saturating; never wraps.
  - Cleared on every state change.
- Reset mid-sequence: both outputs drop asynchronously. No shutdown delay applies.

Optional Feature:
- Macro: DSP_PWR_SEQ_RETRY_EN.
- Defined:
  - FAULT entered with retry_cnt < MAX_RETRY → stay in FAULT for SHDN_DLY_CYC cycles, increment retry_cnt, go to WAIT_PWR (counter=1). fault is high during this wait.
  - retry_cnt == MAX_RETRY → latch in FAULT as in the base behaviour.
  - retry_cnt clears in IDLE and RUN.
  - Adds output retry_cnt [$clog2(MAX_RETRY+1)-1:0].
- Undefined: no retry, no retry_cnt port. FAULT latches until en=0.

Decomposition:
- Package dsp_pwr_seq_pkg:
  - state enum (IDLE, WAIT_PWR, WAIT_PG, WAIT_RST, RUN, SHUTDOWN, FAULT), 3-bit encoding.
  - Default cycle constants.
- Sub-module sync_2ff: generic 2-flop synchronizer with async active-low clear, used for pwr_good.

Test Plan:
(Bench parameters: PWR_DLY_CYC=4, PG_TIMEOUT_CYC=10, RST_DLY_CYC=6, SHDN_DLY_CYC=3.)
- Nominal: en=1 at edge 0, pwr_good=1 at edge 5 → pwron_out rises at edge 4; pg_s high at edge 7; rst_out rises at edge 13; busy=0 from edge 13.
- PG timeout: en=1, pwr_good held 0 → pwron_out=1 at edge 4; FAULT at edge 14; both outputs 0 and fault=1 at edge 14. en=0 at edge 20 → IDLE, fault=0 at edge 21.
- Brownout in RUN: pwr_good→0 → 2 cycles later both outputs 0 in the same cycle, fault=1.
- Shutdown: en=0 in RUN at edge K → rst_out=0 at K+1, pwron_out=0 at K+4, IDLE. Assert rst_out never 1 while pwron_out is 0.
- Async reset in WAIT_RST: rst_n=0 between edges → outputs 0 immediately. Release rst_n with en=1 → full sequence restarts; pwron_out rises at edge 4.
- DSP_PWR_SEQ_RETRY_EN, pwr_good stuck 0, MAX_RETRY=2 → three pwron_out pulses total (initial + 2 retries), then latched fault with retry_cnt=2.

Source files
------------

// File: rtl/dsp_pwr_seq_pkg.sv
// dsp_pwr_seq_pkg: state encoding, default timing constants and a small
// state-decode helper shared by the DSP power-up/reset sequencer.
package dsp_pwr_seq_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PWR = 3'd1,
    WAIT_PG  = 3'd2,
    WAIT_RST = 3'd3,
    RUN      = 3'd4,
    SHUTDOWN = 3'd5,
    FAULT    = 3'd6
  } pwr_state_e;

  // Default board-clock cycle counts
  localparam int unsigned DEF_CNT_W          = 20;
  localparam int unsigned DEF_PWR_DLY_CYC    = 50000;
  localparam int unsigned DEF_PG_TIMEOUT_CYC = 20000;
  localparam int unsigned DEF_RST_DLY_CYC    = 100000;
  localparam int unsigned DEF_SHDN_DLY_CYC   = 1000;
`ifdef DSP_PWR_SEQ_RETRY_EN
  localparam int unsigned DEF_MAX_RETRY      = 3;
`endif

  // busy covers every transitional state; the resting states are IDLE, RUN, FAULT
  function automatic logic isBusyState(input pwr_state_e s);
    return !((s == IDLE) || (s == RUN) || (s == FAULT));
  endfunction

endpackage

// File: rtl/dsp_pwr_seq_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer with asynchronous active-low clear.
// Used to bring the regulator power-good into the clk domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dsp_pwr_seq.sv
// dsp_pwr_seq: timed power-up/reset sequencer for the DSP.
// Raises pwron_out after a programmable delay, waits for power-good, then
// raises rst_out after a second delay. Handles brownout faults and an ordered
// shutdown (rst_out drops first, pwron_out later).
// Optional build macro: DSP_PWR_SEQ_RETRY_EN adds automatic fault retries and
// the retry_cnt output.
module dsp_pwr_seq
  import dsp_pwr_seq_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned PWR_DLY_CYC    = DEF_PWR_DLY_CYC,
  parameter int unsigned PG_TIMEOUT_CYC = DEF_PG_TIMEOUT_CYC,
  parameter int unsigned RST_DLY_CYC    = DEF_RST_DLY_CYC,
  parameter int unsigned SHDN_DLY_CYC   = DEF_SHDN_DLY_CYC
`ifdef DSP_PWR_SEQ_RETRY_EN
  ,
  parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pwr_good,
  output logic pwron_out,
  output logic rst_out,
  output logic busy,
  output logic fault
`ifdef DSP_PWR_SEQ_RETRY_EN
  ,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
`endif
);

  // WAIT_PWR enters with count 1, so its exit compares against the full delay.
  // The other timed states enter with count 0 and leave on the edge where the
  // count would reach the target, hence the "minus one" thresholds.
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_DLY_CYC);
  localparam logic [CNT_W-1:0] PG_LAST   = CNT_W'(PG_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] SHDN_LAST = CNT_W'(SHDN_DLY_CYC - 1);

`ifdef DSP_PWR_SEQ_RETRY_EN
  localparam int unsigned     RW        = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;
`endif

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
  logic             pwron_q, pwron_d;
  logic             rst_q, rst_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             pgSync;

  sync_2ff #(
    .WIDTH(1)
  ) u_pg_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pwr_good),
    .q_o  (pgSync)
  );

  // Next state, counter and decoded outputs; fault conditions outrank en=0
  always_comb begin
    state_d = state_q;
    cntInc  = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));
    cnt_d   = cntInc;
`ifdef DSP_PWR_SEQ_RETRY_EN
    retry_d = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT_PWR;
      end
      WAIT_PWR: begin
        if (!en)                    state_d = IDLE;
        else if (cnt_q >= PWR_LAST) state_d = WAIT_PG;
      end
      WAIT_PG: begin
        if (!pgSync && (cnt_q >= PG_LAST)) state_d = FAULT;
        else if (!en)                      state_d = SHUTDOWN;
        else if (pgSync)                   state_d = WAIT_RST;
      end
      WAIT_RST: begin
        if (!pgSync)                state_d = FAULT;
        else if (!en)               state_d = SHUTDOWN;
        else if (cnt_q >= RST_LAST) state_d = RUN;
      end
      RUN: begin
        if (!pgSync)  state_d = FAULT;
        else if (!en) state_d = SHUTDOWN;
      end
      SHUTDOWN: begin
        if (cnt_q >= SHDN_LAST) state_d = IDLE;
      end
      FAULT: begin
        if (!en) begin
          state_d = IDLE;
        end
`ifdef DSP_PWR_SEQ_RETRY_EN
        else if ((retry_q < RETRY_MAX) && (cnt_q >= SHDN_LAST)) begin
          state_d = WAIT_PWR;
          retry_d = retry_q + RW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = (state_d == WAIT_PWR) ? CNT_W'(1) : '0;
    end

`ifdef DSP_PWR_SEQ_RETRY_EN
    if ((state_d == IDLE) || (state_d == RUN)) retry_d = '0;
`endif

    pwron_d = state_d inside {WAIT_PG, WAIT_RST, RUN, SHUTDOWN};
    rst_d   = (state_d == RUN);
    busy_d  = isBusyState(state_d);
    fault_d = (state_d == FAULT);
  end

  // State, counter and output registers; reset drops both outputs at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pwron_q <= 1'b0;
      rst_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
`ifdef DSP_PWR_SEQ_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwron_q <= pwron_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
`ifdef DSP_PWR_SEQ_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign pwron_out = pwron_q;
  assign rst_out   = rst_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
`ifdef DSP_PWR_SEQ_RETRY_EN
  assign retry_cnt = retry_q;
`endif

endmodule
